// File: rtl/nebula_gpio_walker.sv
`default_nettype none
// ============================================================================
// Module   : nebula_gpio_walker
// Purpose  : Walking-one pattern generator for GPIO pads with prescaled step
//            timing, pass counting, pause and restart control.
// Revision : 1.0
// ============================================================================
module nebula_gpio_walker #(
    parameter int WIDTH = 34,
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             start,
    input  logic [PRE_W-1:0] cfg_prescale,
    input  logic [3:0]       cfg_iterations,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oeb,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ZERO  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [WIDTH-1:0] C_BIT0 = WIDTH'(1);

    logic [2:0]       state_q, state_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [3:0]       pass_q,  pass_d;
    logic [WIDTH-1:0] gpio_q,  gpio_d;
    logic [WIDTH-1:0] oeb_q;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             w_tick;

    // Equality compare only: a lowered prescale lets the counter wrap before ticking.
    assign w_tick = (presc_q == cfg_prescale);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            pass_q  <= '0;
            gpio_q  <= '0;
            oeb_q   <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            pass_q  <= pass_d;
            gpio_q  <= gpio_d;
            oeb_q   <= '0;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        pass_d  = pass_q;
        gpio_d  = gpio_q;
        if (en) begin
            // Every step-to-step transition happens on a tick, which already clears the counter.
            presc_d = w_tick ? '0 : presc_q + PRE_W'(1);
            case (state_q)
                S_IDLE, S_DONE: begin
                    presc_d = '0;
                    if (start) begin
                        state_d = S_ZERO;
                        gpio_d  = '0;
                        pass_d  = '0;
                    end
                end
                S_ZERO: begin
                    if (w_tick) begin
                        state_d = S_SHIFT;
                        gpio_d  = C_BIT0;
                    end
                end
                S_SHIFT: begin
                    if (w_tick) begin
                        if (gpio_q[WIDTH-1]) begin
                            state_d = S_GAP;
                            gpio_d  = '0;
                            pass_d  = pass_q + 4'd1;
                        end else begin
                            gpio_d  = gpio_q << 1;
                        end
                    end
                end
                S_GAP: begin
                    if (w_tick) begin
                        if ((cfg_iterations != 4'd0) && (pass_q == cfg_iterations)) begin
                            state_d = S_DONE;
                            gpio_d  = '0;
                        end else begin
                            state_d = S_SHIFT;
                            gpio_d  = C_BIT0;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    gpio_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy_d = (state_d == S_ZERO) || (state_d == S_SHIFT) || (state_d == S_GAP);
        done_d = (state_d == S_DONE);
    end

    assign gpio_out = gpio_q;
    assign gpio_oeb = oeb_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_nebula_gpio_walker.sv
`default_nettype none
// ============================================================================
// Module   : tb_nebula_gpio_walker
// Purpose  : Directed self-checking bench for nebula_gpio_walker.
// Revision : 1.0
// ============================================================================
module tb_nebula_gpio_walker;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cfg_prescale = 16'd0;
    logic [3:0]  cfg_iterations = 4'd0;
    logic [33:0] gpio_out;
    logic [33:0] gpio_oeb;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    nebula_gpio_walker #(.WIDTH(34), .PRE_W(16)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .en             (en),
        .start          (start),
        .cfg_prescale   (cfg_prescale),
        .cfg_iterations (cfg_iterations),
        .gpio_out       (gpio_out),
        .gpio_oeb       (gpio_oeb),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        start = 1'b0;
        en    = 1'b1;
        nrst  = 1'b0;
        cyc(2);
        nrst  = 1'b1;
        cyc(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin
        logic [33:0] e;
        int          step;

        // Reset state
        #1 nrst = 1'b0;
        #2;
        chk("rst_gpio", gpio_out, 34'h0);
        chk("rst_oeb", gpio_oeb, 34'h3_FFFF_FFFF);
        chk("rst_busy", {33'd0, busy}, 34'd0);
        chk("rst_done", {33'd0, done}, 34'd0);
        cyc(2);
        nrst = 1'b1;
        cyc(1);
        chk("oeb_after_rst", gpio_oeb, 34'h0);
        cyc(5);
        chk("idle_gpio", gpio_out, 34'h0);
        chk("idle_busy", {33'd0, busy}, 34'd0);

        // Prescale 0, two passes, done 71 cycles after start
        cfg_prescale = 16'd0;
        cfg_iterations = 4'd2;
        pulse_start();
        chk("p0_zero", gpio_out, 34'h0);
        chk("p0_zero_busy", {33'd0, busy}, 34'd1);
        for (int k = 1; k <= 34; k++) begin
            cyc(1);
            e = 34'd1 << (k - 1);
            chk("p0_walk", gpio_out, e);
        end
        cyc(1);
        chk("p0_gap1", gpio_out, 34'h0);
        chk("p0_gap1_busy", {33'd0, busy}, 34'd1);
        cyc(1);
        chk("p0_pass2_first", gpio_out, 34'h1);
        cyc(34);
        chk("p0_gap2", gpio_out, 34'h0);
        chk("p0_gap2_done", {33'd0, done}, 34'd0);
        cyc(1);
        chk("p0_done", {33'd0, done}, 34'd1);
        chk("p0_done_busy", {33'd0, busy}, 34'd0);
        chk("p0_done_gpio", gpio_out, 34'h0);
        cyc(3);
        chk("p0_done_hold", {33'd0, done}, 34'd1);

        // Restart from DONE, then start during SHIFT ignored
        cfg_iterations = 4'd1;
        pulse_start();
        chk("rs_zero", gpio_out, 34'h0);
        chk("rs_busy", {33'd0, busy}, 34'd1);
        chk("rs_done", {33'd0, done}, 34'd0);
        cyc(1);
        chk("rs_first", gpio_out, 34'h1);
        cyc(2);
        chk("rs_bit2", gpio_out, 34'h4);
        pulse_start();
        chk("shift_start_ignored", gpio_out, 34'h8);

        // Prescale 3, single pass: every value held 4 cycles, done at 144
        do_reset();
        cfg_prescale = 16'd3;
        cfg_iterations = 4'd1;
        pulse_start();
        chk("p3_zero", gpio_out, 34'h0);
        for (int k = 1; k <= 144; k++) begin
            cyc(1);
            step = k / 4;
            if (step == 0 || step >= 35) e = 34'h0;
            else e = 34'd1 << (step - 1);
            chk("p3_gpio", gpio_out, e);
            chk("p3_done", {33'd0, done}, (k >= 144) ? 34'd1 : 34'd0);
            chk("p3_busy", {33'd0, busy}, (k >= 144) ? 34'd0 : 34'd1);
        end
        cyc(4);
        chk("p3_after_done", gpio_out, 34'h0);

        // Pause while 34'h100 is shown; step length unchanged after resume
        do_reset();
        cfg_prescale = 16'd2;
        cfg_iterations = 4'd0;
        pulse_start();
        cyc(27);
        chk("en_reach_100", gpio_out, 34'h100);
        cyc(1);
        en = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            start = 1'b0;
            chk("en_hold", gpio_out, 34'h100);
            chk("en_hold_busy", {33'd0, busy}, 34'd1);
        end
        en = 1'b1;
        cyc(1);
        chk("en_resume_100", gpio_out, 34'h100);
        cyc(1);
        chk("en_resume_200", gpio_out, 34'h200);
        cyc(2);
        chk("en_still_200", gpio_out, 34'h200);
        cyc(1);
        chk("en_next_400", gpio_out, 34'h400);

        // Free-running beyond 16 passes
        do_reset();
        cfg_prescale = 16'd0;
        cfg_iterations = 4'd0;
        pulse_start();
        for (int k = 1; k <= 600; k++) begin
            cyc(1);
            chk("free_done", {33'd0, done}, 34'd0);
            if (k == 596) chk("free_pass18_first", gpio_out, 34'h1);
        end
        chk("free_busy", {33'd0, busy}, 34'd1);

        // Asynchronous reset mid-sequence
        do_reset();
        pulse_start();
        cyc(16);
        chk("mid_8000", gpio_out, 34'h8000);
        nrst = 1'b0;
        #1;
        chk("mid_rst_gpio", gpio_out, 34'h0);
        chk("mid_rst_oeb", gpio_oeb, 34'h3_FFFF_FFFF);
        chk("mid_rst_busy", {33'd0, busy}, 34'd0);
        cyc(1);
        nrst = 1'b1;
        cyc(5);
        chk("post_rst_gpio", gpio_out, 34'h0);
        chk("post_rst_busy", {33'd0, busy}, 34'd0);
        chk("post_rst_oeb", gpio_oeb, 34'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nebula_gpio_walker.md
NEBULA_GPIO_WALKER -- requirements
Module: nebula_gpio_walker

Interface
REQ-001 Parameter WIDTH, 34, number of walked output bits; bit 0 maps to mprj_io[0], bits 33:1 map to mprj_io[37:5] in the wrapper.
REQ-002 Parameter PRE_W, 16, width of the prescale counter and the cfg_prescale input.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  run enable; low freezes all state (pause).
REQ-006 start  input  1  single-cycle request to begin a sequence.
REQ-007 cfg_prescale  input  PRE_W  step length minus one, in clk cycles.
REQ-008 cfg_iterations  input  4  number of walk passes; 0 means free-running.
REQ-009 gpio_out  output  WIDTH  walking-one pattern.
REQ-010 gpio_oeb  output  WIDTH  pad output enables, active-low.
REQ-011 busy  output  1  high while in ZERO, SHIFT or GAP.
REQ-012 done  output  1  high while in DONE.

Function
REQ-013 FSM states SHALL be IDLE, ZERO, SHIFT, GAP, DONE; encoding is free.
REQ-014 Step tick SHALL assert when the prescale counter equals cfg_prescale; the counter then clears, otherwise it increments; it clears on every state entry; cfg_prescale=0 gives a tick every cycle.
REQ-015 Each pattern step (ZERO hold, each SHIFT position, GAP) SHALL last exactly cfg_prescale+1 enabled cycles.
REQ-016 IDLE -> ZERO on a clock edge with start=1 and en=1; gpio_out = 0.
REQ-017 ZERO holds gpio_out = 0; on tick -> SHIFT with gpio_out = 1 (bit 0 only).
REQ-018 SHIFT on tick with gpio_out[WIDTH-1]=0 shifts gpio_out left by one, zero-filled; exactly one bit is set throughout SHIFT.
REQ-019 SHIFT on tick with gpio_out[WIDTH-1]=1 -> GAP, gpio_out = 0, pass counter increments.
REQ-020 GAP on tick -> DONE if cfg_iterations != 0 and pass counter == cfg_iterations, otherwise -> SHIFT with gpio_out = 1.
REQ-021 Pass counter is 4 bits, clears on IDLE->ZERO, wraps 15->0 silently in free-running mode.
REQ-022 DONE holds gpio_out = 0 and done = 1; start with en=1 -> ZERO (restart, pass counter cleared).
REQ-023 start in ZERO, SHIFT or GAP SHALL be ignored.
REQ-024 en=0 in any state SHALL freeze state, prescale counter, pass counter and gpio_out; start is ignored while en=0.
REQ-025 cfg_prescale and cfg_iterations are sampled live; changes mid-step take effect at the next compare; if the counter already exceeds a lowered cfg_prescale it counts up to wrap-around and ticks on equality.
REQ-026 gpio_oeb SHALL be all ones during reset and all zeros from the first clock edge after nrst deasserts, independent of FSM state.
REQ-027 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-028 nrst low SHALL immediately force state IDLE, gpio_out = 0, gpio_oeb = all ones, busy = 0, done = 0, prescale and pass counters = 0, including mid-sequence.
REQ-029 After nrst rises, the block SHALL wait in IDLE for start; no pattern is emitted spontaneously.

Verification
REQ-030 cfg_prescale=0, cfg_iterations=2, start pulse -> gpio_out 0 for 1 cycle, then 34'h1,34'h2,...,34'h2_0000_0000 one cycle each, 0 for 1 cycle, repeat once, then DONE with done=1 at cycle 71 after start.
REQ-031 cfg_prescale=3, cfg_iterations=1 -> each value held exactly 4 cycles; done asserts 4*36=144 cycles after start; gpio_out=0 thereafter.
REQ-032 en dropped for 10 cycles while gpio_out=34'h100 -> value held 10 extra cycles, sequence resumes with 34'h200 with unchanged step length.
REQ-033 nrst asserted while gpio_out=34'h8000 -> same instant gpio_out=0, gpio_oeb=34'h3_FFFF_FFFF, busy=0; after release, no activity until start.
REQ-034 start pulsed during SHIFT -> ignored; start in DONE -> fresh sequence beginning with ZERO step.
REQ-035 cfg_iterations=0 -> walking continues past 16 passes with busy=1, done never asserted.
